mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Round-robin controller that shares one multi-cycle `mult` unit among NUM_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester at a time, sequences the `mult` start/done protocol, and returns the product to the granted requester with a valid/ready handshake. It sits between the issue logic and the single shared multiplier.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 64, operand and product width

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  NUM_REQ  per-requester operand valid
- req_mcand  in  NUM_REQ x WIDTH  per-requester multiplicand
- req_mplier  in  NUM_REQ x WIDTH  per-requester multiplier
- req_ready  out  NUM_REQ  one-hot grant; the handshake completes when req_valid[i] & req_ready[i]
- resp_valid  out  NUM_REQ  one-hot result valid
- resp_product  out  WIDTH  product for the requester flagged by resp_valid
- resp_ready  in  NUM_REQ  per-requester result accept
- busy  out  1  high in every state except IDLE
- ops_done  out  32  count of completed response handshakes; wraps at 2^32

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready[i] = 1 only for the first requester with req_valid set, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready may depend combinationally on req_valid.
  - On a handshake with requester i: latch mcand, mplier and owner id i; set rr_ptr = (i+1) mod NUM_REQ; go to ISSUE.
- ISSUE:
  - Drive mult start=1 with the latched operands for exactly one cycle.
  - Go to WAIT.
- WAIT:
  - mult start=0.
  - Ignore mult done in the first WAIT cycle, because it may still hold the stale done from the previous operation.
  - From the second WAIT cycle on, done=1 at a clock edge latches the low WIDTH bits of mult product into resp_product and goes to RESP.
- RESP:
  - resp_valid[owner]=1 and resp_product stay stable until resp_ready[owner]=1.
  - On that edge: ops_done increments and the state goes to IDLE.
  - resp_ready from non-owners is ignored.
- Arithmetic: product = (mcand*mplier) mod 2^WIDTH. Signed and unsigned operands give the same bits.
- No new request is granted while busy. A requester with req_valid held high keeps waiting, and its operands must stay stable until it is granted.
- Fairness: with all requesters valid continuously, grants rotate 0,1,2,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 other operations.

## Timing
- Reset values (asserted asynchronously):
  - state=IDLE, rr_ptr=0
  - req_ready=0, resp_valid=0, resp_product=0
  - busy=0, ops_done=0
  - internal `mult` held in reset
- Reset asserted mid-operation: the in-flight operation and its result are discarded. No response is produced after reset is released.
- Latency, with the handshake at edge T:
  - start is high during cycle T..T+1.
  - If mult done is sampled at edge T+1+L (L = multiplier latency, L≥2), resp_valid rises after edge T+1+L.
- Back-to-back: a response handshake at edge R allows a new grant in the IDLE cycle after R. Minimum spacing between grants is L+3 cycles.
- Simultaneous request and response: a requester may assert req_valid while its own resp_valid is high. It is granted only after the response handshake completes.
- ops_done wraps from 0xFFFF_FFFF to 0 with no flag.

## Structure
- Package `mult_arb_pkg`:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - default NUM_REQ and WIDTH constants
  - function for the round-robin pick from the valid vector and pointer
- One sub-module instance: the existing `mult` (mcand, mplier, start, product, done).
  - Its active-high reset is driven from the inverted reset.
  - It is parameterless and 64-bit, so WIDTH=64 is required when `mult` is used.

## Test plan
- Reset release with req_valid=0: all outputs stay at their reset values and busy=0 for 20 cycles.
- Single requester 2 with mcand=2, mplier=3: one handshake, resp_valid=4'b0100, resp_product=6. ops_done=1 after resp_ready.
- All four requesters valid with mcand=i+1, mplier=-1: grants in order 0,1,2,3,0. Products are -1,-2,-3,-4 (two's complement, 64-bit), each returned to the correct owner.
- resp_ready held low for 10 cycles: resp_valid and resp_product stay stable, no req_ready is asserted, busy stays 1.
- Reset asserted during WAIT for mcand=-20, mplier=5: no resp_valid after release, and the next request for (7,6) returns 42.
- Random 64-bit operands, 1000 operations, random resp_ready stalls: every product equals a*b mod 2^64, and ops_done=1000.

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// Shared types and helpers for the round-robin multiplier arbiter.
// The round-robin pick works on a vector padded to the widest supported requester count.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_WIDTH   = 64;
  localparam int MAX_REQ         = 8;

  // Returns {found, index} for the first valid requester at or above ptr, wrapping modulo num.
  // Walking the offsets from far to near lets the nearest hit overwrite the others.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0] ptr,
                                         input int num);
    logic [3:0] result;
    logic [2:0] idx;
    int pos;
    result = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < num) begin
        pos = (int'(ptr) + k) % num;
        idx = pos[2:0];
        if (valid[idx]) begin
          result = {1'b1, idx};
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mult_arbiter_mult.sv
// Shared 64-bit multi-cycle multiplier: one radix-16 digit of the multiplier per cycle.
// done rises 16 cycles after start is sampled and stays high until the next start.
module mult (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] mcand,
  input  logic [63:0] mplier,
  input  logic        start,
  output logic [63:0] product,
  output logic        done
);

  logic [63:0] a_sh;
  logic [63:0] b_sh;
  logic [63:0] acc;
  logic [63:0] partial;
  logic [4:0]  cnt;

  always_comb begin
    partial = '0;
    for (int k = 0; k < 4; k++) begin
      if (b_sh[k]) begin
        partial = partial + (a_sh << k);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      a_sh <= mcand;
      b_sh <= mplier;
      acc  <= '0;
      cnt  <= 5'd16;
      done <= 1'b0;
    end else if (cnt != 5'd0) begin
      acc  <= acc + partial;
      a_sh <= a_sh << 4;
      b_sh <= b_sh >> 4;
      cnt  <= cnt - 5'd1;
      if (cnt == 5'd1) begin
        done <= 1'b1;
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin controller sharing one multi-cycle mult unit among NUM_REQ requesters.
// The shared mult is fixed at 64 bits, so WIDTH must stay 64 while it is instantiated.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_mcand,
  input  logic [NUM_REQ*WIDTH-1:0] req_mplier,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_product,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic                     busy,
  output logic [31:0]              ops_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t state, state_next;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] grant_idx;
  logic [3:0]       pick;
  logic             grant_found;
  logic             handshake;
  logic             resp_accept;
  logic             wait_first;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] grant_a;
  logic [WIDTH-1:0] grant_b;
  logic [WIDTH-1:0] mult_product;
  logic             mult_start;
  logic             mult_done;

  assign pick        = rr_pick(MAX_REQ'(req_valid), 3'(rr_ptr), NUM_REQ);
  assign grant_found = pick[3];
  assign grant_idx   = IDX_W'(pick[2:0]);
  assign grant_a     = req_mcand[grant_idx*WIDTH +: WIDTH];
  assign grant_b     = req_mplier[grant_idx*WIDTH +: WIDTH];
  assign handshake   = (state == IDLE) && grant_found;
  assign resp_accept = (state == RESP) && resp_ready[owner];
  assign busy        = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The picked requester's valid is known high, so a grant in IDLE is always a completed handshake.
  always_comb begin
    state_next = state;
    mult_start = 1'b0;
    req_ready  = '0;
    resp_valid = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          state_next           = ISSUE;
        end
      end
      ISSUE: begin
        mult_start = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (!wait_first && mult_done) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid[owner] = 1'b1;
        if (resp_ready[owner]) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // wait_first masks a done level that may be left over from the previous operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= '0;
      owner        <= '0;
      op_a         <= '0;
      op_b         <= '0;
      wait_first   <= 1'b0;
      resp_product <= '0;
      ops_done     <= '0;
    end else begin
      if (handshake) begin
        op_a   <= grant_a;
        op_b   <= grant_b;
        owner  <= grant_idx;
        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      wait_first <= (state == ISSUE);
      if ((state == WAIT) && (state_next == RESP)) begin
        resp_product <= mult_product;
      end
      if (resp_accept) begin
        ops_done <= ops_done + 32'd1;
      end
    end
  end

  mult u_mult (
    .clock   (clock),
    .reset   (~reset),
    .mcand   (op_a),
    .mplier  (op_b),
    .start   (mult_start),
    .product (mult_product),
    .done    (mult_done)
  );

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: vector table, scoreboard of expected responses,
// and hand-written sequences for stalls, fairness and reset mid-operation.
module tb_mult_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 64;

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] prod;
    int          stall;
  } vec_t;

  typedef struct {
    int          id;
    logic [63:0] prod;
  } exp_t;

  logic                     clock;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_mcand;
  logic [NUM_REQ*WIDTH-1:0] req_mplier;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [WIDTH-1:0]         resp_product;
  logic [NUM_REQ-1:0]       resp_ready;
  logic                     busy;
  logic [31:0]              ops_done;

  int   compared   = 0;
  int   mismatched = 0;
  int   exp_ops    = 0;
  exp_t sb[$];
  vec_t vecs[7];

  mult_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_mcand    (req_mcand),
    .req_mplier   (req_mplier),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_product (resp_product),
    .resp_ready   (resp_ready),
    .busy         (busy),
    .ops_done     (ops_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] onehot(input int id);
    return 4'(1 << id);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyReset();
    @(negedge clock);
    reset      = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    sb.delete();
    exp_ops = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic applyStimulus(input int id, input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] prod);
    @(negedge clock);
    req_valid[id]                  = 1'b1;
    req_mcand[id*WIDTH +: WIDTH]  = a;
    req_mplier[id*WIDTH +: WIDTH] = b;
    sb.push_back('{id, prod});
    #1;
  endtask

  task automatic waitGrant(input int id);
    int n = 0;
    while (req_ready == '0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput("grant", 64'(req_ready), 64'(onehot(id)));
    @(posedge clock);
    #1;
  endtask

  task automatic serveResponse(input int stall);
    int          n = 0;
    exp_t        e;
    logic [63:0] held;
    while (resp_valid == '0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (resp_valid == '0) begin
      checkOutput("resp_timeout", 64'(resp_valid), 64'(1));
      return;
    end
    if (sb.size() == 0) begin
      checkOutput("unexpected_resp", 64'(resp_valid), 64'(0));
      return;
    end
    e = sb.pop_front();
    checkOutput("resp_valid", 64'(resp_valid), 64'(onehot(e.id)));
    checkOutput("product", resp_product, e.prod);
    held = resp_product;
    for (int s = 0; s < stall; s++) begin
      resp_ready = 4'($urandom) & ~onehot(e.id);
      @(negedge clock);
      checkOutput("hold_valid", 64'(resp_valid), 64'(onehot(e.id)));
      checkOutput("hold_product", resp_product, held);
      checkOutput("hold_no_grant", 64'(req_ready), 64'(0));
      checkOutput("hold_busy", 64'(busy), 64'(1));
    end
    resp_ready = onehot(e.id);
    @(posedge clock);
    #1;
    resp_ready = '0;
    exp_ops++;
    checkOutput("ops_done", 64'(ops_done), 64'(exp_ops));
    checkOutput("resp_cleared", 64'(resp_valid), 64'(0));
  endtask

  task automatic runOp(input int id, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] prod, input int stall);
    applyStimulus(id, a, b, prod);
    waitGrant(id);
    req_valid[id] = 1'b0;
    serveResponse(stall);
  endtask

  initial begin
    logic        seen;
    logic [63:0] a;
    logic [63:0] b;
    int          id;

    vecs[0] = '{2, 64'd2, 64'd3, 64'd6, 0};
    vecs[1] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1};
    vecs[2] = '{3, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 0};
    vecs[3] = '{1, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 2};
    vecs[4] = '{2, 64'h1234, 64'h10, 64'h12340, 0};
    vecs[5] = '{0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 3};
    vecs[6] = '{3, 64'd0, 64'hDEAD_BEEF_0123_4567, 64'd0, 0};

    reset      = 1'b0;
    req_valid  = '0;
    req_mcand  = '0;
    req_mplier = '0;
    resp_ready = '0;

    // Reset values while reset is held, then 20 quiet cycles after release.
    @(negedge clock);
    checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'(0));
    checkOutput("rst_product", resp_product, 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_ops_done", 64'(ops_done), 64'(0));
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      checkOutput("idle_outputs", 64'({req_ready, resp_valid, busy}), 64'(0));
      checkOutput("idle_counts", {resp_product[31:0], ops_done}, 64'(0));
    end

    for (int v = 0; v < 7; v++) begin
      runOp(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].prod, vecs[v].stall);
    end

    // Long stall on requester 1 while requester 3 waits; 3 is granted only afterwards.
    applyStimulus(1, 64'd5, 64'd9, 64'd45);
    waitGrant(1);
    req_valid[1] = 1'b0;
    applyStimulus(3, 64'd11, 64'd13, 64'd143);
    serveResponse(10);
    waitGrant(3);
    req_valid[3] = 1'b0;
    serveResponse(0);

    // Fairness: all four valid continuously, grants rotate 0,1,2,3,0.
    applyReset();
    @(negedge clock);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]                  = 1'b1;
      req_mcand[i*WIDTH +: WIDTH]  = 64'(i + 1);
      req_mplier[i*WIDTH +: WIDTH] = 64'hFFFF_FFFF_FFFF_FFFF;
    end
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{k % NUM_REQ, 64'd0 - 64'((k % NUM_REQ) + 1)});
    end
    #1;
    for (int k = 0; k < 5; k++) begin
      waitGrant(k % NUM_REQ);
      serveResponse(0);
    end
    req_valid = '0;

    // Reset asserted while the multiplier is running: the operation is dropped.
    applyStimulus(1, 64'd0 - 64'd20, 64'd5, 64'd0 - 64'd100);
    waitGrant(1);
    req_valid[1] = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_busy", 64'(busy), 64'(0));
    checkOutput("async_rst_resp", 64'(resp_valid), 64'(0));
    sb.delete();
    exp_ops = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (resp_valid != '0 || busy) seen = 1'b1;
    end
    checkOutput("no_resp_after_reset", 64'(seen), 64'(0));
    runOp(2, 64'd7, 64'd6, 64'd42, 0);

    // Random operands with random stalls and stray non-owner resp_ready.
    applyReset();
    for (int r = 0; r < 1000; r++) begin
      id = int'($urandom_range(0, NUM_REQ - 1));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      runOp(id, a, b, a * b, int'($urandom_range(0, 3)));
    end
    checkOutput("ops_done_1000", 64'(ops_done), 64'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
